// File: rtl/sort_host_if.sv
// Stream and sorter-port bundle for sort_host: producer/consumer streams plus
// the wr/addr/data/start/ready port of the byte sorter.
interface sort_host_if #(
  parameter int W  = 8,
  parameter int AW = 3
);
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          srt_start;
  logic          srt_wr;
  logic [AW-1:0] srt_addr;
  logic [W-1:0]  srt_data_in;
  logic          srt_ready;
  logic [W-1:0]  srt_data_out;

  modport master (
    input  in_valid, in_data, out_ready, srt_ready, srt_data_out,
    output in_ready, out_valid, out_data, srt_start, srt_wr, srt_addr, srt_data_in
  );

  modport slave (
    output in_valid, in_data, out_ready, srt_ready, srt_data_out,
    input  in_ready, out_valid, out_data, srt_start, srt_wr, srt_addr, srt_data_in
  );
endinterface

// File: rtl/sort_host.sv
// Initiator for the N-entry byte sorter: loads a batch from the input stream,
// starts the sort, waits for completion and streams the sorted bytes out.
module sort_host #(
  parameter int N      = 8,
  parameter int W      = 8,
  parameter int AW     = 3,
  parameter int RD_LAT = 2
) (
  input  logic       clk,
  input  logic       nrst,
  sort_host_if.master bus,
  output logic       busy,
  output logic       done
);
  localparam int CW = AW + 1;
  localparam int DW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [CW-1:0] LAST     = CW'(N - 1);
  localparam logic [DW-1:0] DLY_LAST = DW'(RD_LAT - 1);

  localparam logic [2:0] S_LOAD      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_WAIT_BUSY = 3'd2;
  localparam logic [2:0] S_WAIT_DONE = 3'd3;
  localparam logic [2:0] S_READ      = 3'd4;
  localparam logic [2:0] S_OUT       = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] idx_q, idx_d;
  logic [DW-1:0] dly_q, dly_d;
  logic [W-1:0]  out_data_q, out_data_d;

  logic load_rdy, in_xfer, out_xfer;

  // Reset is folded into the ready term so the write port is quiet while nrst is low.
  assign load_rdy = (state_q == S_LOAD) && bus.srt_ready && nrst;
  assign in_xfer  = load_rdy && bus.in_valid;
  assign out_xfer = (state_q == S_OUT) && bus.out_ready;

  // NOTE: every _d gets its default first, so no path through the case can infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    dly_d      = dly_q;
    out_data_d = out_data_q;
    case (state_q)
      S_LOAD: begin
        if (in_xfer) begin
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            state_d = S_START;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_START:     state_d = S_WAIT_BUSY;
      S_WAIT_BUSY: if (!bus.srt_ready) state_d = S_WAIT_DONE;
      S_WAIT_DONE: begin
        if (bus.srt_ready) begin
          idx_d   = '0;
          dly_d   = '0;
          state_d = S_READ;
        end
      end
      S_READ: begin
        if (dly_q == DLY_LAST) begin
          out_data_d = bus.srt_data_out;
          dly_d      = '0;
          state_d    = S_OUT;
        end else begin
          dly_d = dly_q + DW'(1);
        end
      end
      S_OUT: begin
        if (bus.out_ready) begin
          if (idx_q == LAST) begin
            cnt_d   = '0;
            state_d = S_LOAD;
          end else begin
            idx_d   = idx_q + CW'(1);
            state_d = S_READ;
          end
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  // NOTE: state is updated only with non-blocking assignments so all flops sample together.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= S_LOAD;
      cnt_q      <= '0;
      idx_q      <= '0;
      dly_q      <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      dly_q      <= dly_d;
      out_data_q <= out_data_d;
    end
  end

  // The read address is held through OUT so a stalled consumer sees no address churn.
  always_comb begin
    bus.srt_addr = '0;
    case (state_q)
      S_LOAD:        bus.srt_addr = cnt_q[AW-1:0];
      S_READ, S_OUT: bus.srt_addr = idx_q[AW-1:0];
      default:       bus.srt_addr = '0;
    endcase
  end

  assign bus.in_ready    = load_rdy;
  assign bus.srt_wr      = in_xfer;
  assign bus.srt_data_in = in_xfer ? bus.in_data : '0;
  assign bus.srt_start   = (state_q == S_START);
  assign bus.out_valid   = (state_q == S_OUT);
  assign bus.out_data    = out_data_q;
  assign busy            = !((state_q == S_LOAD) && (cnt_q == '0));
  assign done            = out_xfer && (idx_q == LAST);
endmodule

// File: tb/tb_sort_host.sv
// Directed bench for sort_host: two instances (RD_LAT 2 and 3), each wired to a
// behavioural sorter that drops ready for 20 cycles and sorts its memory ascending.
module tb_sort_host;
  typedef logic [7:0] batch_t [8];

  logic clk = 1'b0;
  logic nrst = 1'b0;
  logic busy2, done2, busy3, done3;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sort_host_if #(.W(8), .AW(3)) b2 ();
  sort_host_if #(.W(8), .AW(3)) b3 ();

  sort_host #(.N(8), .W(8), .AW(3), .RD_LAT(2)) u_dut2 (
    .clk(clk), .nrst(nrst), .bus(b2.master), .busy(busy2), .done(done2));
  sort_host #(.N(8), .W(8), .AW(3), .RD_LAT(3)) u_dut3 (
    .clk(clk), .nrst(nrst), .bus(b3.master), .busy(busy3), .done(done3));

  function automatic logic [7:0][7:0] sort8(input logic [7:0][7:0] v);
    logic [7:0][7:0] r;
    logic [7:0] t;
    r = v;
    for (int i = 0; i < 7; i++)
      for (int j = 0; j < 7 - i; j++)
        if (r[j] > r[j+1]) begin t = r[j]; r[j] = r[j+1]; r[j+1] = t; end
    return r;
  endfunction

  logic       m_ready [2];
  logic [7:0] m_dout  [2];
  assign b2.srt_ready    = m_ready[0];
  assign b2.srt_data_out = m_dout[0];
  assign b3.srt_ready    = m_ready[1];
  assign b3.srt_data_out = m_dout[1];

  // Sorter model: read data appears RD_LAT cycles after the address is first driven.
  for (genvar g = 0; g < 2; g++) begin : g_srt
    localparam int LAT = (g == 0) ? 2 : 3;
    logic            wr, start;
    logic [2:0]      addr;
    logic [7:0]      din;
    logic [7:0][7:0] mem;
    logic [7:0]      pipe [LAT-1];
    logic            rdy = 1'b1;
    int              busy_cnt = 0;
    assign wr    = (g == 0) ? b2.srt_wr      : b3.srt_wr;
    assign start = (g == 0) ? b2.srt_start   : b3.srt_start;
    assign addr  = (g == 0) ? b2.srt_addr    : b3.srt_addr;
    assign din   = (g == 0) ? b2.srt_data_in : b3.srt_data_in;
    always @(posedge clk) begin
      if (wr) mem[addr] <= din;
      if (start && rdy) begin
        rdy <= 1'b0;
        busy_cnt <= 20;
      end else if (busy_cnt == 1) begin
        mem <= sort8(mem);
        rdy <= 1'b1;
        busy_cnt <= 0;
      end else if (busy_cnt > 1) begin
        busy_cnt <= busy_cnt - 1;
      end
      pipe[0] <= mem[addr];
      for (int i = 1; i < LAT - 1; i++) pipe[i] <= pipe[i-1];
    end
    assign m_ready[g] = rdy;
    assign m_dout[g]  = pipe[LAT-2];
  end

  // Loads n bytes into the RD_LAT=2 instance; with gaps, in_valid is low every other cycle.
  task automatic load_batch(input batch_t v, input bit gaps, input int n);
    int i = 0;
    int c = 0;
    while (i < n) begin
      @(negedge clk);
      c++;
      if (gaps && (c % 2 == 0)) begin
        b2.in_valid = 1'b0;
        b2.in_data  = 8'h5A;
        #1;
        checks++; if (b2.srt_wr !== 1'b0) begin failures++; $display("FAIL gap_wr[%0d]: got %b want 0", i, b2.srt_wr); end
        checks++; if (b2.in_ready !== 1'b1) begin failures++; $display("FAIL gap_in_ready[%0d]: got %b want 1", i, b2.in_ready); end
        checks++; if (b2.srt_start !== 1'b0) begin failures++; $display("FAIL gap_start[%0d]: got %b want 0", i, b2.srt_start); end
      end else begin
        b2.in_valid = 1'b1;
        b2.in_data  = v[i];
        #1;
        checks++; if (b2.in_ready !== 1'b1) begin failures++; $display("FAIL load_in_ready[%0d]: got %b want 1", i, b2.in_ready); end
        checks++; if (b2.srt_wr !== 1'b1) begin failures++; $display("FAIL load_wr[%0d]: got %b want 1", i, b2.srt_wr); end
        checks++; if (b2.srt_addr !== 3'(i)) begin failures++; $display("FAIL load_addr[%0d]: got %0d want %0d", i, b2.srt_addr, i); end
        checks++; if (b2.srt_data_in !== v[i]) begin failures++; $display("FAIL load_data[%0d]: got %0d want %0d", i, b2.srt_data_in, v[i]); end
        checks++; if (b2.srt_start !== 1'b0) begin failures++; $display("FAIL load_start[%0d]: got %b want 0", i, b2.srt_start); end
        checks++; if (busy2 !== (i != 0)) begin failures++; $display("FAIL load_busy[%0d]: got %b want %b", i, busy2, (i != 0)); end
        if (i == 0) begin
          checks++; if (done2 !== 1'b0) begin failures++; $display("FAIL load_done: got %b want 0", done2); end
          checks++; if (b2.out_valid !== 1'b0) begin failures++; $display("FAIL load_out_valid: got %b want 0", b2.out_valid); end
        end
        i++;
      end
    end
  endtask

  // Collects 8 bytes from the RD_LAT=2 instance; out_ready is held low stall_len cycles on byte stall_k.
  task automatic run_output(input batch_t exp, input int stall_k, input int stall_len);
    int k = 0, cyc = 0, stall = 0, starts = 0, wrs = 0;
    bit rdy;
    while (k < 8 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      b2.in_valid = 1'b0;
      rdy = !(k == stall_k && stall < stall_len);
      b2.out_ready = rdy;
      #1;
      if (b2.srt_start) starts++;
      if (b2.srt_wr) wrs++;
      if (b2.out_valid) begin
        checks++; if (b2.out_data !== exp[k]) begin failures++; $display("FAIL out_data[%0d]: got %0d want %0d", k, b2.out_data, exp[k]); end
        if (!rdy) begin
          stall++;
          checks++; if (b2.srt_addr !== 3'(k)) begin failures++; $display("FAIL stall_addr[%0d]: got %0d want %0d", k, b2.srt_addr, k); end
          checks++; if (done2 !== 1'b0) begin failures++; $display("FAIL stall_done[%0d]: got %b want 0", k, done2); end
        end else begin
          checks++; if (done2 !== (k == 7)) begin failures++; $display("FAIL done[%0d]: got %b want %b", k, done2, (k == 7)); end
          k++;
        end
      end
    end
    checks++; if (k != 8) begin failures++; $display("FAIL out_count: got %0d want 8 (cycle budget expired)", k); end
    checks++; if (starts != 1) begin failures++; $display("FAIL start_pulses: got %0d want 1", starts); end
    checks++; if (wrs != 0) begin failures++; $display("FAIL wr_outside_load: got %0d want 0", wrs); end
    checks++; if (stall != stall_len) begin failures++; $display("FAIL stall_cycles: got %0d want %0d", stall, stall_len); end
  endtask

  task automatic test_reset();
    b2.in_valid = 1'b0; b2.in_data = 8'hFF; b2.out_ready = 1'b0;
    b3.in_valid = 1'b0; b3.in_data = 8'h00; b3.out_ready = 1'b0;
    nrst = 1'b0;
    #12;
    checks++; if ({b2.in_ready, b2.out_valid, b2.srt_start, b2.srt_wr, busy2, done2} !== 6'b0) begin
      failures++; $display("FAIL reset_ctrl: got %b want 000000", {b2.in_ready, b2.out_valid, b2.srt_start, b2.srt_wr, busy2, done2}); end
    checks++; if ({b2.out_data, b2.srt_addr, b2.srt_data_in} !== 19'b0) begin
      failures++; $display("FAIL reset_data: got %h want 0", {b2.out_data, b2.srt_addr, b2.srt_data_in}); end
    @(negedge clk);
    nrst = 1'b1;
    #1;
    checks++; if (b2.in_ready !== 1'b1) begin failures++; $display("FAIL post_reset_in_ready: got %b want 1", b2.in_ready); end
  endtask

  task automatic test_sort_backpressure();
    batch_t v = '{8'd8, 8'd3, 8'd7, 8'd1, 8'd6, 8'd2, 8'd5, 8'd4};
    batch_t e = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    load_batch(v, 1'b0, 8);
    run_output(e, 2, 5);
  endtask

  task automatic test_back_to_back_gaps();
    batch_t v = '{8'd40, 8'd10, 8'd30, 8'd20, 8'd80, 8'd60, 8'd70, 8'd50};
    batch_t e = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80};
    load_batch(v, 1'b1, 8);
    run_output(e, 8, 0);
  endtask

  task automatic test_async_reset();
    batch_t v = '{8'd17, 8'd16, 8'd15, 8'd14, 8'd13, 8'd12, 8'd11, 8'd10};
    int guard = 0;
    load_batch(v, 1'b0, 8);
    do begin
      @(negedge clk);
      b2.in_valid = 1'b0;
      guard++;
    end while (b2.srt_ready !== 1'b0 && guard < 50);
    checks++; if (b2.srt_ready !== 1'b0) begin failures++; $display("FAIL sorter_busy_seen: got %b want 0", b2.srt_ready); end
    repeat (3) @(negedge clk);
    checks++; if (busy2 !== 1'b1) begin failures++; $display("FAIL wait_busy_flag: got %b want 1", busy2); end
    #3;
    nrst = 1'b0;
    b2.in_valid = 1'b1;
    b2.in_data  = 8'hAA;
    #1;
    checks++; if ({b2.in_ready, b2.out_valid, b2.srt_start, b2.srt_wr, busy2, done2} !== 6'b0) begin
      failures++; $display("FAIL areset_ctrl: got %b want 000000", {b2.in_ready, b2.out_valid, b2.srt_start, b2.srt_wr, busy2, done2}); end
    checks++; if (b2.out_data !== 8'd0) begin failures++; $display("FAIL areset_out_data: got %0d want 0", b2.out_data); end
    checks++; if ({b2.srt_addr, b2.srt_data_in} !== 11'b0) begin failures++; $display("FAIL areset_srt_bus: got %h want 0", {b2.srt_addr, b2.srt_data_in}); end
    @(negedge clk);
    b2.in_valid = 1'b0;
    nrst = 1'b1;
    #1;
    checks++; if (b2.in_ready !== b2.srt_ready) begin failures++; $display("FAIL release_in_ready: got %b want %b", b2.in_ready, b2.srt_ready); end
    guard = 0;
    while (b2.srt_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      #1;
      guard++;
    end
    checks++; if (b2.in_ready !== 1'b1) begin failures++; $display("FAIL idle_in_ready: got %b want 1", b2.in_ready); end
    checks++; if (busy2 !== 1'b0) begin failures++; $display("FAIL idle_busy: got %b want 0", busy2); end
  endtask

  task automatic test_duplicates_back_to_back();
    batch_t v  = '{8'd255, 8'd0, 8'd255, 8'd0, 8'd255, 8'd0, 8'd255, 8'd0};
    batch_t e  = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd255, 8'd255, 8'd255, 8'd255};
    batch_t v2 = '{8'd9, 8'd200, 8'd50, 8'd7, 8'd7, 8'd128, 8'd1, 8'd64};
    batch_t e2 = '{8'd1, 8'd7, 8'd7, 8'd9, 8'd50, 8'd64, 8'd128, 8'd200};
    load_batch(v, 1'b0, 8);
    run_output(e, 8, 0);
    load_batch(v2, 1'b0, 8);
    run_output(e2, 5, 2);
  endtask

  task automatic test_rd_lat3();
    batch_t v = '{8'd5, 8'd9, 8'd1, 8'd200, 8'd77, 8'd3, 8'd128, 8'd64};
    batch_t e = '{8'd1, 8'd3, 8'd5, 8'd9, 8'd64, 8'd77, 8'd128, 8'd200};
    int k = 0, cyc = 0, last = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      b3.in_valid = 1'b1;
      b3.in_data  = v[i];
      #1;
      checks++; if (b3.srt_wr !== 1'b1 || b3.srt_addr !== 3'(i)) begin
        failures++; $display("FAIL lat3_load[%0d]: got wr=%b addr=%0d want wr=1 addr=%0d", i, b3.srt_wr, b3.srt_addr, i); end
    end
    while (k < 8 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      b3.in_valid  = 1'b0;
      b3.out_ready = 1'b1;
      #1;
      if (b3.out_valid) begin
        checks++; if (b3.out_data !== e[k]) begin failures++; $display("FAIL lat3_data[%0d]: got %0d want %0d", k, b3.out_data, e[k]); end
        if (k > 0) begin
          checks++; if (cyc - last != 4) begin failures++; $display("FAIL lat3_interval[%0d]: got %0d want 4", k, cyc - last); end
        end
        last = cyc;
        k++;
      end
    end
    checks++; if (k != 8) begin failures++; $display("FAIL lat3_count: got %0d want 8 (cycle budget expired)", k); end
  endtask

  initial begin
    test_reset();
    test_sort_backpressure();
    test_back_to_back_gaps();
    test_async_reset();
    test_duplicates_back_to_back();
    test_rd_lat3();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sort_host.md
Name: sort_host

Overview:
- Initiator-side controller for the 8-entry byte sorter.
- Accepts an input stream of N bytes and writes them into the sorter through its wr/addr/data_in port.
- Pulses start, waits for the sorter to finish, reads back the N sorted bytes, and emits them on an output stream.
- Sits between a streaming producer/consumer and the sorter instance.

Parameters:
N, 8, number of entries per batch (sorter depth)
W, 8, data width
AW, 3, sorter address width, equal to clog2(N)
RD_LAT, 2, cycles from driving srt_addr with srt_wr=0 until srt_data_out is valid

Ports:
clk  in  1  clock, all logic on posedge
nrst  in  1  asynchronous active-low reset
in_valid  in  1  producer has a byte
in_data  in  W  producer byte
in_ready  out  1  host accepts in_data this cycle
out_valid  out  1  sorted byte available
out_data  out  W  sorted byte
out_ready  in  1  consumer takes out_data this cycle
srt_start  out  1  one-cycle start pulse to the sorter
srt_wr  out  1  sorter write enable
srt_addr  out  AW  sorter address (write or read)
srt_data_in  out  W  sorter write data
srt_ready  in  1  sorter idle (1) / sorting (0)
srt_data_out  in  W  sorter read data
busy  out  1  high in every state except LOAD with load count 0
done  out  1  one-cycle pulse when the N-th sorted byte is accepted

Behaviour:
- Reset (nrst=0, async): state=LOAD, counters=0, out_data=0. All other outputs are 0 (in_ready, out_valid, srt_start, srt_wr, srt_addr, srt_data_in, busy, done). Reset mid-batch aborts the batch; the partial sorter contents are ignored.
- Handshakes: transfer occurs when valid&ready are both high on a posedge.
  - out_valid and out_data hold stable until out_ready.
  - in_ready does not depend on in_valid.
- LOAD:
  - in_ready = srt_ready.
  - On each in transfer, the same cycle drives srt_wr=1, srt_addr=cnt, srt_data_in=in_data (combinational pass-through), then cnt++.
  - srt_wr=0 whenever no transfer occurs.
  - The transfer with cnt=N-1 goes to START and sets cnt=0.
- START: srt_start=1 for exactly one cycle, in_ready=0, then WAIT_BUSY.
- WAIT_BUSY: wait for srt_ready=0, then WAIT_DONE.
- WAIT_DONE: wait for srt_ready=1, then READ with idx=0.
- READ:
  - Drive srt_wr=0 and srt_addr=idx for RD_LAT cycles, using a delay counter.
  - On the last cycle, capture srt_data_out into out_data, then go to OUT.
- OUT:
  - out_valid=1.
  - On out_ready: if idx=N-1, pulse done, clear out_valid, go to LOAD with cnt=0.
  - Otherwise idx++ and go to READ.
  - Throughput: one byte per RD_LAT+1 cycles minimum.
- srt_wr is never 1 outside LOAD, and srt_start is never 1 outside START.
- Counters are AW+1 bits wide; there is no wrap-around within a batch.
- in_valid during non-LOAD states is ignored; the producer stalls.
- Back-to-back batches are supported: LOAD accepts again the cycle after done.
- Simultaneous events:
  - srt_ready already 0 on entering WAIT_BUSY: the next cycle goes to WAIT_DONE.
  - srt_ready toggling in LOAD only gates in_ready.

Test Plan:
- Load 8,3,7,1,6,2,5,4 with in_valid held high → srt_wr high 8 consecutive cycles, srt_addr 0..7, one srt_start pulse.
  - Sorter model drops ready for 20 cycles.
  - out stream 1,2,3,4,5,6,7,8, then done=1 for one cycle.
- Output backpressure: out_ready low for 5 cycles on the 3rd byte → out_valid/out_data=3 held stable, no srt_addr change, order preserved.
- Input gaps: in_valid toggles every other cycle → srt_wr only on transfer cycles, addresses contiguous 0..7, start only after the 8th byte.
- Async reset: assert nrst=0 during WAIT_DONE → all outputs 0 immediately. After release, in_ready=srt_ready, cnt restarts at 0 (next write to addr 0).
- Duplicate values 255,0,255,0,... → output 0,0,0,0,255,255,255,255. A second batch starts right after done with no idle state leak (busy follows spec).
- RD_LAT=3 variant → out_data matches the model byte read from the correct address; no early capture.
